// File: rtl/axis_packet_fifo_pkg.sv
// Shared types for the AXI-Stream packet FIFO.
// Holds the FSM encoding and default geometry.
package axis_packet_fifo_pkg;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  localparam int DEF_ABITS = 7;
  localparam int DEF_DBITS = 64;

endpackage

// File: rtl/axis_packet_fifo_ram.sv
// Simple dual-port storage for the packet FIFO.
// Synchronous write, asynchronous read, word = {tlast, data}.
module fifo_ram #(
  parameter int ABITS = 7,
  parameter int WBITS = 65
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WBITS-1:0] rdata
);

  logic [WBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with tlast framing and store-and-forward mode.
// Oversize packets are dropped; status flags come from pointers.
module axis_packet_fifo
  import axis_packet_fifo_pkg::*;
#(
  parameter int ABITS       = DEF_ABITS,
  parameter int DBITS       = DEF_DBITS,
  parameter bit PACKET_MODE = 1'b1,
  parameter int AF_THRESH   = (2**ABITS) - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DBITS-1:0] din,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [DBITS-1:0] dout,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [ABITS:0]   level,
  output logic [ABITS:0]   pkt_count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             drop
);

  localparam logic [ABITS:0] FULL_CNT = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] AF_LVL = (ABITS+1)'(AF_THRESH);
  localparam logic [ABITS:0] AE_LVL = (ABITS+1)'(AE_THRESH);

  logic [ABITS:0] wr_ptr;
  logic [ABITS:0] commit_ptr;
  logic [ABITS:0] rd_ptr;
  logic [ABITS:0] pending;
  logic [DBITS:0] rd_word;
  state_t         state;
  logic           alive;
  logic           full;
  logic           spill;
  logic           wr_fire;
  logic           rd_fire;
  logic           ovf_fire;
  logic           store;
  logic           pkt_inc;
  logic           pkt_dec;

  assign level   = wr_ptr - rd_ptr;
  assign pending = wr_ptr - commit_ptr;
  assign full    = level == FULL_CNT;

  // A partial packet spanning the whole memory can never commit;
  // accept the next beat so it can be discarded instead of stalling.
  assign spill = PACKET_MODE && (pending == FULL_CNT)
              && (state == ST_PASS);

  assign s_axis_tready = alive
                      && ((state == ST_DROP) || !full || spill);

  assign wr_fire  = s_axis_tvalid && s_axis_tready;
  assign ovf_fire = wr_fire && spill;
  assign store    = wr_fire && (state == ST_PASS) && !spill;

  assign m_axis_tvalid = commit_ptr != rd_ptr;
  assign rd_fire       = m_axis_tvalid && m_axis_tready;
  assign dout          = rd_word[DBITS-1:0];
  assign m_axis_tlast  = m_axis_tvalid && rd_word[DBITS];

  assign pkt_inc = store && s_axis_tlast;
  assign pkt_dec = rd_fire && m_axis_tlast;

  assign almost_full  = level >= AF_LVL;
  assign almost_empty = level <= AE_LVL;

  fifo_ram #(
    .ABITS (ABITS),
    .WBITS (DBITS + 1)
  ) u_ram (
    .clock (clock),
    .we    (store),
    .waddr (wr_ptr[ABITS-1:0]),
    .wdata ({s_axis_tlast, din}),
    .raddr (rd_ptr[ABITS-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      state      <= ST_PASS;
      alive      <= 1'b0;
      drop       <= 1'b0;
    end else begin
      alive <= 1'b1;
      drop  <= ovf_fire;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!PACKET_MODE || s_axis_tlast)
          commit_ptr <= wr_ptr + 1'b1;
      end
      if (ovf_fire) wr_ptr <= commit_ptr;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (pkt_inc && !pkt_dec)
        pkt_count <= pkt_count + 1'b1;
      else if (!pkt_inc && pkt_dec)
        pkt_count <= pkt_count - 1'b1;
      unique case (state)
        ST_PASS:
          if (ovf_fire && !s_axis_tlast) state <= ST_DROP;
        ST_DROP:
          if (wr_fire && s_axis_tlast) state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench: stream instance [0] and packet instance [1].
// Expected values are hand-computed per scenario.
module tb_axis_packet_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] din  [2];
  logic [63:0] dout [2];
  logic        sv [2];
  logic        sl [2];
  logic        sr [2];
  logic        mv [2];
  logic        ml [2];
  logic        mr [2];
  logic        af [2];
  logic        ae [2];
  logic        drp [2];
  logic [3:0]  lvl [2];
  logic [3:0]  pc [2];

  int total = 0;
  int bad = 0;

  logic [63:0] rx5 [5] = '{64'h200, 64'h201, 64'h202, 64'h203, 64'h300};
  logic        rl5 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        wl5 [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0]  pc5 [5] = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd1};

  axis_packet_fifo #(
    .ABITS(3), .DBITS(64), .PACKET_MODE(1'b0),
    .AF_THRESH(6), .AE_THRESH(2)
  ) u_str (
    .clock(clk), .reset(reset),
    .din(din[0]), .s_axis_tvalid(sv[0]),
    .s_axis_tlast(sl[0]), .s_axis_tready(sr[0]),
    .dout(dout[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tlast(ml[0]), .m_axis_tready(mr[0]),
    .level(lvl[0]), .pkt_count(pc[0]),
    .almost_full(af[0]), .almost_empty(ae[0]),
    .drop(drp[0])
  );

  axis_packet_fifo #(
    .ABITS(3), .DBITS(64), .PACKET_MODE(1'b1),
    .AF_THRESH(6), .AE_THRESH(2)
  ) u_pkt (
    .clock(clk), .reset(reset),
    .din(din[1]), .s_axis_tvalid(sv[1]),
    .s_axis_tlast(sl[1]), .s_axis_tready(sr[1]),
    .dout(dout[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tlast(ml[1]), .m_axis_tready(mr[1]),
    .level(lvl[1]), .pkt_count(pc[1]),
    .almost_full(af[1]), .almost_empty(ae[1]),
    .drop(drp[1])
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [63:0] d,
                      input logic l);
    din[i] = d;
    sl[i]  = l;
    sv[i]  = 1'b1;
    tick();
    sv[i] = 1'b0;
    sl[i] = 1'b0;
  endtask

  task automatic pop(input int i, input logic [63:0] d,
                     input logic l, input string tag);
    mr[i] = 1'b1;
    chk({tag, "_valid"}, 64'(mv[i]), 64'd1);
    chk({tag, "_data"}, dout[i], d);
    chk({tag, "_last"}, 64'(ml[i]), 64'(l));
    tick();
    mr[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; sv[i] = 0; sl[i] = 0; mr[i] = 0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_tready", 64'(sr[i]), 64'd0);
      chk("rst_tvalid", 64'(mv[i]), 64'd0);
      chk("rst_tlast", 64'(ml[i]), 64'd0);
      chk("rst_level", 64'(lvl[i]), 64'd0);
      chk("rst_pkt", 64'(pc[i]), 64'd0);
      chk("rst_af", 64'(af[i]), 64'd0);
      chk("rst_ae", 64'(ae[i]), 64'd1);
      chk("rst_drop", 64'(drp[i]), 64'd0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_tready_s", 64'(sr[0]), 64'd1);
    chk("post_rst_tready_p", 64'(sr[1]), 64'd1);

    // 1: stream fill then drain
    push(0, 64'h1, 1'b0);
    chk("t1_first_valid", 64'(mv[0]), 64'd1);
    for (int k = 2; k <= 6; k++) push(0, 64'(k), 1'b0);
    chk("t1_level6", 64'(lvl[0]), 64'd6);
    chk("t1_af", 64'(af[0]), 64'd1);
    chk("t1_ae_low", 64'(ae[0]), 64'd0);
    for (int k = 1; k <= 6; k++) pop(0, 64'(k), 1'b0, "t1_rd");
    chk("t1_level0", 64'(lvl[0]), 64'd0);
    chk("t1_ae", 64'(ae[0]), 64'd1);
    chk("t1_empty", 64'(mv[0]), 64'd0);

    // 2: stream full and backpressure
    for (int k = 1; k <= 8; k++) begin
      chk("t2_ready", 64'(sr[0]), 64'd1);
      push(0, 64'h20 + 64'(k), 1'b0);
    end
    chk("t2_full_ready", 64'(sr[0]), 64'd0);
    chk("t2_level8", 64'(lvl[0]), 64'd8);
    din[0] = 64'h29;
    sv[0]  = 1'b1;
    tick();
    chk("t2_held_level", 64'(lvl[0]), 64'd8);
    chk("t2_held_ready", 64'(sr[0]), 64'd0);
    mr[0] = 1'b1;
    chk("t2_rd_data", dout[0], 64'h21);
    tick();
    mr[0] = 1'b0;
    chk("t2_ready_back", 64'(sr[0]), 64'd1);
    chk("t2_level7", 64'(lvl[0]), 64'd7);
    tick();
    sv[0] = 1'b0;
    chk("t2_level8b", 64'(lvl[0]), 64'd8);
    for (int k = 2; k <= 9; k++)
      pop(0, 64'h20 + 64'(k), 1'b0, "t2_rd");
    chk("t2_drained", 64'(lvl[0]), 64'd0);

    // 3: packet store-and-forward
    push(1, 64'hA, 1'b0);
    chk("t3_hold_a", 64'(mv[1]), 64'd0);
    push(1, 64'hB, 1'b0);
    chk("t3_hold_b", 64'(mv[1]), 64'd0);
    push(1, 64'hC, 1'b1);
    chk("t3_valid", 64'(mv[1]), 64'd1);
    chk("t3_pkt1", 64'(pc[1]), 64'd1);
    chk("t3_level3", 64'(lvl[1]), 64'd3);
    pop(1, 64'hA, 1'b0, "t3_a");
    pop(1, 64'hB, 1'b0, "t3_b");
    pop(1, 64'hC, 1'b1, "t3_c");
    chk("t3_pkt0", 64'(pc[1]), 64'd0);
    chk("t3_empty", 64'(mv[1]), 64'd0);

    // 4: oversize packet dropped
    for (int k = 1; k <= 8; k++) begin
      chk("t4_ready", 64'(sr[1]), 64'd1);
      push(1, 64'h100 + 64'(k), 1'b0);
    end
    chk("t4_level8", 64'(lvl[1]), 64'd8);
    chk("t4_nodrop", 64'(drp[1]), 64'd0);
    chk("t4_ovf_ready", 64'(sr[1]), 64'd1);
    push(1, 64'h109, 1'b0);
    chk("t4_drop", 64'(drp[1]), 64'd1);
    chk("t4_level0", 64'(lvl[1]), 64'd0);
    chk("t4_drop_ready", 64'(sr[1]), 64'd1);
    push(1, 64'h10A, 1'b1);
    chk("t4_drop_end", 64'(drp[1]), 64'd0);
    chk("t4_level0b", 64'(lvl[1]), 64'd0);
    chk("t4_pkt0", 64'(pc[1]), 64'd0);
    chk("t4_novalid", 64'(mv[1]), 64'd0);
    push(1, 64'h55, 1'b0);
    push(1, 64'h66, 1'b1);
    chk("t4_pkt1", 64'(pc[1]), 64'd1);
    chk("t4_level2", 64'(lvl[1]), 64'd2);
    pop(1, 64'h55, 1'b0, "t4_55");
    pop(1, 64'h66, 1'b1, "t4_66");

    // 5: simultaneous read and write
    for (int k = 0; k < 4; k++)
      push(1, 64'h200 + 64'(k), k == 3);
    chk("t5_level4", 64'(lvl[1]), 64'd4);
    chk("t5_pkt1", 64'(pc[1]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      din[1] = 64'h300 + 64'(k);
      sl[1]  = wl5[k];
      sv[1]  = 1'b1;
      mr[1]  = 1'b1;
      chk("t5_ready", 64'(sr[1]), 64'd1);
      chk("t5_valid", 64'(mv[1]), 64'd1);
      chk("t5_data", dout[1], rx5[k]);
      chk("t5_last", 64'(ml[1]), 64'(rl5[k]));
      tick();
      chk("t5_level", 64'(lvl[1]), 64'd4);
      chk("t5_pkt", 64'(pc[1]), 64'(pc5[k]));
    end
    sv[1] = 1'b0;
    sl[1] = 1'b0;
    mr[1] = 1'b0;

    // 6: reset mid-packet
    for (int k = 0; k < 3; k++) push(1, 64'h400 + 64'(k), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_level0", 64'(lvl[1]), 64'd0);
    chk("t6_novalid", 64'(mv[1]), 64'd0);
    chk("t6_pkt0", 64'(pc[1]), 64'd0);
    chk("t6_rst_ready", 64'(sr[1]), 64'd0);
    tick();
    chk("t6_ready", 64'(sr[1]), 64'd1);
    push(1, 64'h77, 1'b0);
    push(1, 64'h88, 1'b1);
    chk("t6_pkt1", 64'(pc[1]), 64'd1);
    pop(1, 64'h77, 1'b0, "t6_77");
    pop(1, 64'h88, 1'b1, "t6_88");
    chk("t6_done_level", 64'(lvl[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
